mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   MEM-stage initiator for the word-wide data memory (64 x 32, registered read, 1-cycle latency).
//   Accepts byte/half/word loads and stores from the pipeline and issues mem_read/mem_write cycles.
//   Sign- or zero-extends load data; sub-word stores are done as read-modify-write.
//   req_ready low = pipeline stall.
// PARAMETERS
//   ADDR_W  6  word-address width driven to data memory (depth = 2**ADDR_W words)
// PORTS
//   clk        in   1       clock, all state on posedge
//   reset      in   1       asynchronous, active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       request accepted on posedge when req_valid & req_ready
//   req_we     in   1       1 = store, 0 = load
//   req_size   in   2       00 byte, 01 half, 10 word (11 treated as word)
//   req_signed in   1       load: 1 = sign-extend, 0 = zero-extend
//   req_addr   in   32      byte address, little-endian (byte 0 = bits [7:0])
//   req_wdata  in   32      store data, right-justified
//   rsp_valid  out  1       one-cycle pulse: access complete
//   rsp_rdata  out  32      extended load data, valid with rsp_valid (0 for stores)
//   rsp_err    out  1       misaligned request, valid with rsp_valid
//   mem_read   out  1       to data memory
//   mem_write  out  1       to data memory
//   mem_addr   out  ADDR_W  word address = req_addr[ADDR_W+1:2]; upper bits ignored (wrap)
//   mem_wdata  out  32      to data memory
//   mem_rdata  in   32      from data memory, valid the cycle after mem_read
// BEHAVIOUR
//   Moore FSM, states IDLE, RD, CAP, WR, RESP. All outputs decode from registers.
//   Reset: state IDLE; every output 0 except req_ready=1; latched request regs 0.
//   IDLE: req_ready=1. On accept, latch addr/size/signed/we/wdata, then:
//     load -> RD; word store -> WR; byte/half store -> RD; misaligned (see CONFIG) -> RESP.
//   RD: mem_read=1, mem_addr = latched word addr -> CAP.
//   CAP: mem_rdata valid.
//     Load: rdata_q <= extend(lane extract) -> RESP.
//     Store: wdata_q <= merge(mem_rdata, new lane) -> WR.
//   WR: mem_write=1, mem_wdata=wdata_q (word store: req_wdata as latched) -> RESP.
//   RESP: rsp_valid=1, req_ready=0 -> IDLE. Next accept is earliest the cycle after RESP.
//   mem_read and mem_write are never high together; both are 0 in IDLE/CAP/RESP.
//   Latency from accept edge to rsp_valid cycle: load 3; word store 2; sub-word store 4; misaligned 1.
//   Lanes: byte = addr[1:0]; half = addr[1] (upper half when 1).
//   Extension is by bit 7 or bit 15 of the extracted lane.
//   Reset mid-operation: FSM returns to IDLE asynchronously; mem_write/mem_read drop in that same
//     cycle; an in-flight RMW is abandoned (memory keeps the old word); no rsp_valid is issued.
// CONFIGURATION
//   MEM_ACCESS_ALIGN_CHK_EN defined:
//     half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//     It goes IDLE->RESP with rsp_err=1 and rsp_rdata=0; no memory cycle is issued.
//   Not defined:
//     addr[0] is ignored for half and addr[1:0] for word (forced aligned).
//     rsp_err is tied 0.
// STRUCTURE
//   mem_access_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encoding constants.
//   Sub-module mem_lane_align (combinational):
//     extract+extend for loads, byte/half merge for stores; instantiated once, shared by CAP.
// TESTING (DM[3]=32'h8899_AABB preloaded, accept at cycle 0)
//   1 Load byte signed, addr 0x0D:
//     mem_read=1 cycle1 with mem_addr=3; rsp_valid cycle3 with rsp_rdata=0xFFFF_FFAA.
//     Unsigned repeat -> 0x0000_00AA.
//   2 Store half 0x1234, addr 0x0E:
//     mem_read cycle1; mem_write cycle3 with mem_addr=3, mem_wdata=0x1234_AABB;
//     rsp_valid cycle4; a following word load returns 0x1234_AABB.
//   3 Store word 0xDEAD_BEEF, addr 0x10:
//     mem_write cycle1 with mem_addr=4; no mem_read at any cycle; rsp_valid cycle2, rsp_rdata=0.
//   4 Word load, addr 0x11, macro on:
//     rsp_valid+rsp_err cycle1; mem_read/mem_write stay 0.
//     Macro off: reads word 4, rsp_err=0.
//   5 req_valid held high for 3 loads:
//     accepts only in IDLE; req_ready=0 cycles 1-3; next accept cycle4; responses in order.
//   6 reset asserted during WR of test 2:
//     mem_write falls immediately; DM[3] unchanged; no rsp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Package: mem_access_pkg
// Shared encodings for the MEM-stage data memory initiator:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - controller FSM state encoding
//   - misalignment helper used when MEM_ACCESS_ALIGN_CHK_EN is defined
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // size[1] set covers both 2'b10 and 2'b11, so 2'b11 is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size[1])
      return off != 2'b00;
    else if (size == SZ_HALF)
      return off[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Interface: mem_access_if
// Bundles the pipeline request/response handshake and the data memory bus.
//   slave  : view taken by mem_access_ctrl (accepts requests, drives memory)
//   master : view taken by the pipeline / memory side (testbench)
// Signals:
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata  request
//   rsp_valid/rsp_rdata/rsp_err                                        response
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata                    data memory
interface mem_access_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Module: mem_lane_align (combinational)
// Lane handling for sub-word accesses on a little-endian 32-bit word.
// Ports:
//   rdata_i  in  32  word read from data memory
//   wdata_i  in  32  right-justified store data
//   size_i   in  2   access size (byte / half / word)
//   sign_i   in  1   1 = sign-extend loads
//   off_i    in  2   byte offset within the word (addr[1:0])
//   load_o   out 32  extracted and extended load data
//   merge_o  out 32  rdata_i with the store lane replaced by wdata_i
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata_i[{off_i, 3'b000} +: 8];
    half_v  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    merge_o = wdata_i;
    if (size_i == SZ_BYTE) begin
      load_o  = {{24{sign_i & byte_v[7]}}, byte_v};
      merge_o = rdata_i;
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (size_i == SZ_HALF) begin
      load_o  = {{16{sign_i & half_v[15]}}, half_v};
      merge_o = off_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                         : {rdata_i[31:16], wdata_i[15:0]};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Module: mem_access_ctrl
// MEM-stage initiator for a word-wide data memory with a 1-cycle registered read.
// Byte/half/word loads are extracted and extended; sub-word stores are performed
// as read-modify-write. req_ready low stalls the pipeline.
// Ports:
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous, active-high reset
//   bus    mem_access_if.slave (request, response and data memory signals)
// Build option:
//   MEM_ACCESS_ALIGN_CHK_EN  defined: misaligned half/word requests respond at once
//                            with rsp_err=1 and no memory cycle.
//                            undefined: low address bits are ignored, rsp_err tied 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; latches it on accept
// ST_RD   | mem_read issued for the latched word address
// ST_CAP  | mem_rdata valid: extend for loads, merge lane for stores
// ST_WR   | mem_write issued with the (merged) store word
// ST_RESP | rsp_valid pulse, request not accepted
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  logic                err_q, err_d;
`endif

  logic [31:0]         load_data;
  logic [31:0]         merge_data;

  mem_lane_align u_align (
    .rdata_i (bus.mem_rdata),
    .wdata_i (wdata_q),
    .size_i  (size_q),
    .sign_i  (signed_q),
    .off_i   (addr_q[1:0]),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr[ADDR_W+1:0];
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          // Cleared on accept so stores and errors respond with zero data.
          rdata_d  = '0;
          if (bus.req_we && bus.req_size[1])
            state_d = ST_WR;
          else
            state_d = ST_RD;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
          err_d = is_misaligned(bus.req_size, bus.req_addr[1:0]);
          if (err_d)
            state_d = ST_RESP;
`endif
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        if (we_q) begin
          wdata_d = merge_data;
          state_d = ST_WR;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_read  = (state_q == ST_RD);
  assign bus.mem_write = (state_q == ST_WR);
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  assign bus.rsp_err   = err_q & (state_q == ST_RESP);
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory model: 64 x 32, registered read, plus a preload port.
  logic [31:0] dm [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld_en)
      dm[ld_idx] <= ld_val;
    else if (bus.mem_write)
      dm[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)
      bus.mem_rdata <= dm[bus.mem_addr];
  end

  int total = 0;
  int bad   = 0;

  // Per-cycle capture of one operation; index = cycles after the accept edge.
  logic        cr_rdy  [16];
  logic        cr_rd   [16];
  logic        cr_wr   [16];
  logic        cr_rv   [16];
  logic        cr_err  [16];
  logic [5:0]  cr_addr [16];
  logic [31:0] cr_wd   [16];
  logic [31:0] cr_rdat [16];

  task automatic capture(input int c);
    cr_rdy[c]  = bus.req_ready;
    cr_rd[c]   = bus.mem_read;
    cr_wr[c]   = bus.mem_write;
    cr_rv[c]   = bus.rsp_valid;
    cr_err[c]  = bus.rsp_err;
    cr_addr[c] = bus.mem_addr;
    cr_wd[c]   = bus.mem_wdata;
    cr_rdat[c] = bus.rsp_rdata;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // Called #1 after a clock edge with the DUT idle: request is accepted on the next edge.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int n);
    drive_req(we, sz, sg, a, wd);
    capture(0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.req_valid = 1'b0;
      capture(c);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
    end
    total++;
    if ({bus.rsp_valid, bus.mem_read, bus.mem_write, bus.rsp_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000",
                      {bus.rsp_valid, bus.mem_read, bus.mem_write, bus.rsp_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0",
                      bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle ready=%b rv=%b exp ready=1 rv=0",
                      bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_load;
    logic [31:0] t_addr [6];
    logic [1:0]  t_size [6];
    logic        t_sgn  [6];
    logic [31:0] t_exp  [6];
    t_addr = '{32'h0D, 32'h0D, 32'h0F, 32'h0C, 32'h0E, 32'h0E};
    t_size = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF};
    t_sgn  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t_exp  = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_FF88,
               32'hFFFF_AABB, 32'h0000_8899, 32'hFFFF_8899};
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, t_size[i], t_sgn[i], t_addr[i], 32'h0, 4);
      total++;
      if (cr_rdy[0] !== 1'b1) begin
        bad++; $display("FAIL load%0d_ready got=%b exp=1", i, cr_rdy[0]);
      end
      for (int c = 1; c <= 4; c++) begin
        total++;
        if (cr_rd[c] !== (c == 1) || cr_wr[c] !== 1'b0 || cr_rv[c] !== (c == 3)) begin
          bad++; $display("FAIL load%0d_cyc%0d rd/wr/rv got=%b%b%b exp=%b0%b",
                          i, c, cr_rd[c], cr_wr[c], cr_rv[c], c == 1, c == 3);
        end
      end
      total++;
      if (cr_addr[1] !== 6'd3) begin
        bad++; $display("FAIL load%0d_addr got=%0d exp=3", i, cr_addr[1]);
      end
      total++;
      if (cr_rdat[3] !== t_exp[i]) begin
        bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, cr_rdat[3], t_exp[i]);
      end
    end
  endtask

  task automatic test_store_sub;
    run_op(1'b1, SZ_HALF, 1'b0, 32'h0E, 32'h0000_1234, 5);
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (cr_rd[c] !== (c == 1) || cr_wr[c] !== (c == 3) || cr_rv[c] !== (c == 4)) begin
        bad++; $display("FAIL sth_cyc%0d rd/wr/rv got=%b%b%b exp=%b%b%b",
                        c, cr_rd[c], cr_wr[c], cr_rv[c], c == 1, c == 3, c == 4);
      end
    end
    total++;
    if (cr_addr[3] !== 6'd3 || cr_wd[3] !== 32'h1234_AABB) begin
      bad++; $display("FAIL sth_write addr=%0d wdata=%h exp addr=3 wdata=1234aabb",
                      cr_addr[3], cr_wd[3]);
    end
    total++;
    if (cr_rdat[4] !== 32'h0) begin
      bad++; $display("FAIL sth_rdata got=%h exp=0", cr_rdat[4]);
    end
    run_op(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 4);
    total++;
    if (cr_rdat[3] !== 32'h1234_AABB) begin
      bad++; $display("FAIL sth_readback got=%h exp=1234aabb", cr_rdat[3]);
    end
    run_op(1'b1, SZ_BYTE, 1'b0, 32'h0D, 32'hFFFF_FF55, 5);
    total++;
    if (cr_wr[3] !== 1'b1 || cr_wd[3] !== 32'h1234_55BB || cr_rv[4] !== 1'b1) begin
      bad++; $display("FAIL stb_merge wr=%b wdata=%h rv=%b exp wr=1 wdata=123455bb rv=1",
                      cr_wr[3], cr_wd[3], cr_rv[4]);
    end
    total++;
    if (dm[3] !== 32'h1234_55BB) begin
      bad++; $display("FAIL stb_mem got=%h exp=123455bb", dm[3]);
    end
  endtask

  task automatic test_store_word;
    run_op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 3);
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (cr_rd[c] !== 1'b0 || cr_wr[c] !== (c == 1) || cr_rv[c] !== (c == 2)) begin
        bad++; $display("FAIL stw_cyc%0d rd/wr/rv got=%b%b%b exp=0%b%b",
                        c, cr_rd[c], cr_wr[c], cr_rv[c], c == 1, c == 2);
      end
    end
    total++;
    if (cr_addr[1] !== 6'd4 || cr_wd[1] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL stw_write addr=%0d wdata=%h exp addr=4 wdata=deadbeef",
                      cr_addr[1], cr_wd[1]);
    end
    total++;
    if (cr_rdat[2] !== 32'h0 || dm[4] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL stw_result rdata=%h mem=%h exp rdata=0 mem=deadbeef",
                      cr_rdat[2], dm[4]);
    end
  endtask

  task automatic test_misaligned;
    run_op(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 4);
`ifdef MEM_ACCESS_ALIGN_CHK_EN
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (cr_rd[c] !== 1'b0 || cr_wr[c] !== 1'b0 || cr_rv[c] !== (c == 1)) begin
        bad++; $display("FAIL mis_cyc%0d rd/wr/rv got=%b%b%b exp=00%b",
                        c, cr_rd[c], cr_wr[c], cr_rv[c], c == 1);
      end
    end
    total++;
    if (cr_err[1] !== 1'b1 || cr_rdat[1] !== 32'h0) begin
      bad++; $display("FAIL mis_err err=%b rdata=%h exp err=1 rdata=0", cr_err[1], cr_rdat[1]);
    end
`else
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (cr_rd[c] !== (c == 1) || cr_wr[c] !== 1'b0 || cr_rv[c] !== (c == 3)) begin
        bad++; $display("FAIL mis_cyc%0d rd/wr/rv got=%b%b%b exp=%b0%b",
                        c, cr_rd[c], cr_wr[c], cr_rv[c], c == 1, c == 3);
      end
    end
    total++;
    if (cr_addr[1] !== 6'd4 || cr_rdat[3] !== 32'hDEAD_BEEF || cr_err[3] !== 1'b0) begin
      bad++; $display("FAIL mis_forced addr=%0d rdata=%h err=%b exp addr=4 rdata=deadbeef err=0",
                      cr_addr[1], cr_rdat[3], cr_err[3]);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] q_addr [3];
    logic [1:0]  q_size [3];
    logic [31:0] q_exp  [3];
    int          r;
    q_addr = '{32'h0C, 32'h10, 32'h0F};
    q_size = '{SZ_WORD, 2'b11, SZ_BYTE};
    q_exp  = '{32'h1234_55BB, 32'hDEAD_BEEF, 32'h0000_0012};
    drive_req(1'b0, q_size[0], 1'b1, q_addr[0], 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      capture(c);
      r = (c + 3) / 4;
      if (r <= 2)
        drive_req(1'b0, q_size[r], 1'b1, q_addr[r], 32'h0);
      else
        bus.req_valid = 1'b0;
    end
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (cr_rdy[c] !== (c % 4 == 0) || cr_rv[c] !== (c % 4 == 3)) begin
        bad++; $display("FAIL b2b_cyc%0d ready/rv got=%b%b exp=%b%b",
                        c, cr_rdy[c], cr_rv[c], c % 4 == 0, c % 4 == 3);
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cr_rdat[4*k+3] !== q_exp[k]) begin
        bad++; $display("FAIL b2b_rsp%0d got=%h exp=%h", k, cr_rdat[4*k+3], q_exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive_req(1'b1, SZ_HALF, 1'b0, 32'h0E, 32'h0000_CAFE);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.mem_write !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_wr got=%b exp=1", bus.mem_write);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop wr=%b rd=%b rv=%b exp=000",
                      bus.mem_write, bus.mem_read, bus.rsp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        bad++; $display("FAIL rstmid_after%0d rv=%b ready=%b exp rv=0 ready=1",
                        c, bus.rsp_valid, bus.req_ready);
      end
    end
    total++;
    if (dm[3] !== 32'h1234_55BB) begin
      bad++; $display("FAIL rstmid_mem got=%h exp=123455bb", dm[3]);
    end
    run_op(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 4);
    total++;
    if (cr_rv[3] !== 1'b1 || cr_rdat[3] !== 32'h1234_55BB) begin
      bad++; $display("FAIL rstmid_recover rv=%b rdata=%h exp rv=1 rdata=123455bb",
                      cr_rv[3], cr_rdat[3]);
    end
  endtask

  initial begin
    test_reset();
    preload(6'd3, 32'h8899_AABB);
    test_load();
    test_store_sub();
    test_store_word();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
